// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the EX-stage multiply/divide engine:
// funct3 op encoding, engine state encoding and architectural constants.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 step shared by multiply (shift-add, multiplier in the low half)
// and restoring divide (remainder in the high half, quotient shifted into the low half).
module muldiv_iter_core
    import riscv_pkg::*;
(
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    input  logic              div_mode_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] sub_diff;

    always_comb begin
        add_sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Trial subtract on the left-shifted remainder; bit XLEN set means it went negative.
        sub_diff = acc_i[2*XLEN-1:XLEN-1] - {1'b0, opnd_i};
        if (!div_mode_i) begin
            acc_o = {add_sum, acc_i[XLEN-1:1]};
        end else if (!sub_diff[XLEN]) begin
            acc_o = {sub_diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
        end else begin
            acc_o = {acc_i[2*XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage (IDLE -> BUSY -> DONE).
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply; divide is always iterative.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_muldiv_start,
    input  logic [2:0]      ex_muldiv_op,
    input  logic [XLEN-1:0] ex_rs1_data,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic            hazard_id_ex_clear,
    output logic            muldiv_stall_req,
    output logic [XLEN-1:0] muldiv_result,
    output logic            muldiv_result_valid,
    output logic [1:0]      muldiv_dbg_state
);
    import riscv_pkg::*;

    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_q, op_d, op_in;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic            a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic            early_q, early_d;
    logic [2*XLEN-1:0] acc_q, acc_d, core_acc;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            in_div, in_sdiv, a_neg_in, b_neg_in, early_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN-1:0] q_raw, r_raw, quo_fin, rem_fin, iter_res, early_res;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
`endif

    muldiv_iter_core u_core (
        .acc_i      (acc_q),
        .opnd_i     (opnd_q),
        .div_mode_i (op_q[2]),
        .acc_o      (core_acc)
    );

    // Operand decode on the issue cycle: signedness, magnitudes and early-out detection.
    always_comb begin
        op_in    = muldiv_op_e'(ex_muldiv_op);
        in_div   = ex_muldiv_op[2];
        in_sdiv  = in_div & ~ex_muldiv_op[0];
        a_neg_in = ex_rs1_data[XLEN-1] &
                   (in_div ? in_sdiv : (op_in == OP_MULH || op_in == OP_MULHSU));
        b_neg_in = ex_rs2_data[XLEN-1] & (in_div ? in_sdiv : (op_in == OP_MULH));
        a_mag    = a_neg_in ? -ex_rs1_data : ex_rs1_data;
        b_mag    = b_neg_in ? -ex_rs2_data : ex_rs2_data;
        early_in = in_div & ((ex_rs2_data == '0) |
                   (in_sdiv & (ex_rs1_data == INT_MIN) & (ex_rs2_data == '1)));
    end

    // Sign fix-up and result selection applied to the last iteration's accumulator.
    always_comb begin
        prod_fin  = (a_neg_q ^ b_neg_q) ? -core_acc : core_acc;
        q_raw     = core_acc[XLEN-1:0];
        r_raw     = core_acc[2*XLEN-1:XLEN];
        quo_fin   = (a_neg_q ^ b_neg_q) ? -q_raw : q_raw;
        rem_fin   = a_neg_q ? -r_raw : r_raw;
        if (op_q[2]) begin
            iter_res = op_q[1] ? rem_fin : quo_fin;
        end else begin
            iter_res = (op_q == OP_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
        end
        if (b_q == '0) begin
            early_res = op_q[1] ? a_q : DIV_BY_ZERO_Q;
        end else begin
            early_res = op_q[1] ? '0 : INT_MIN;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        fast_a    = {{XLEN{a_neg_q}}, a_q};
        fast_b    = {{XLEN{b_neg_q}}, b_q};
        fast_prod = fast_a * fast_b;
    end
`endif

    // Stall protocol: muldiv_stall_req is asserted combinationally in the issue cycle and
    // throughout BUSY, and is released in DONE (result strobe) or immediately on
    // hazard_id_ex_clear, which aborts the operation and outranks a new start.
    always_comb begin
        state_d             = state_q;
        op_d                = op_q;
        a_d                 = a_q;
        b_d                 = b_q;
        a_neg_d             = a_neg_q;
        b_neg_d             = b_neg_q;
        early_d             = early_q;
        acc_d               = acc_q;
        opnd_d              = opnd_q;
        cnt_d               = cnt_q;
        result_d            = result_q;
        muldiv_stall_req    = 1'b0;
        muldiv_result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                muldiv_stall_req = ex_muldiv_start;
                if (ex_muldiv_start) begin
                    op_d    = op_in;
                    a_d     = ex_rs1_data;
                    b_d     = ex_rs2_data;
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                    early_d = early_in;
                    acc_d   = {{XLEN{1'b0}}, (in_div ? a_mag : b_mag)};
                    opnd_d  = in_div ? b_mag : a_mag;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                muldiv_stall_req = 1'b1;
                if (early_q) begin
                    result_d = early_res;
                    state_d  = DONE;
`ifdef MULDIV_FAST_MUL_EN
                end else if (!op_q[2]) begin
                    result_d = (op_q == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
                    state_d  = DONE;
`endif
                end else begin
                    acc_d = core_acc;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        result_d = iter_res;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                muldiv_result_valid = 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (hazard_id_ex_clear) begin
            state_d             = IDLE;
            muldiv_stall_req    = 1'b0;
            muldiv_result_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            early_q  <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            early_q  <= early_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign muldiv_result    = result_q;
    assign muldiv_dbg_state = state_q;

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide engine in the EX stage. It takes operands from ID/EX, drives a stall request into the hazard unit to freeze the front-end and EX while it iterates, and presents one result for exactly one cycle when done. It honours the hazard unit's ID/EX clear as an abort. It is the producer side of the stall protocol: the hazard unit consumes `muldiv_stall_req`, and this block consumes `hazard_id_ex_clear`.

## Interface

Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `ITERS`, default 32: number of iterations in the iterative multiply and divide paths.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: synchronous active-low reset.
- `ex_muldiv_start`, in, 1: ID/EX holds a valid M-extension instruction.
- `ex_muldiv_op`, in, 3: funct3. Encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `ex_rs1_data`, in, XLEN: operand a.
- `ex_rs2_data`, in, XLEN: operand b.
- `hazard_id_ex_clear`, in, 1: flush from the hazard unit. Aborts any operation.
- `muldiv_stall_req`, out, 1: request to the hazard unit to stall the front-end and hold ID/EX.
- `muldiv_result`, out, XLEN: result. Valid only while `muldiv_result_valid` is high.
- `muldiv_result_valid`, out, 1: single-cycle result strobe.

## Operation

FSM with states IDLE, BUSY, DONE.

- **IDLE**
  - `muldiv_stall_req` = `ex_muldiv_start & !hazard_id_ex_clear`. This is combinational, so the stall takes effect in the issue cycle.
  - On an accepted start: latch op, a, b, and the sign flags, then go to BUSY.
- **BUSY**
  - `muldiv_stall_req` = 1.
  - Operands held in registers, so changes on the input ports are ignored.
  - Iteration counter counts 0..ITERS-1.
  - Leave for DONE after the last iteration, or after one cycle on an early-out.
- **DONE**
  - `muldiv_stall_req` = 0 and `muldiv_result_valid` = 1 for exactly this cycle, so the instruction leaves EX at the end of the cycle.
  - Next state is always IDLE. A start seen during DONE is ignored, because it is the same instruction.
- **Multiply**
  - Take the magnitudes of signed operands (rs1 signed for MULH and MULHSU; rs2 signed for MULH only).
  - Radix-2 shift-add into a 2*XLEN accumulator.
  - Negate the product if the operand signs differ.
  - MUL returns bits [31:0]; the other multiply ops return [63:32].
- **Divide**
  - Restoring radix-2 on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - REM and REMU return the remainder; DIV and DIVU return the quotient.
- **Early-outs** (BUSY lasts 1 cycle):
  - b == 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
  - Signed a == 0x80000000 with b == 0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- **Flush**
  - `hazard_id_ex_clear` in any state forces IDLE next cycle.
  - No `muldiv_result_valid` is produced, and `muldiv_stall_req` drops in that same cycle.
  - Clear outranks start.
- **Reset**
  - Takes effect from any state.
  - Next cycle: state IDLE, counter 0, result register 0, `muldiv_result_valid` 0, `muldiv_stall_req` 0.

## Timing

- Start accepted in cycle T.
- Iterative op: BUSY in cycles T+1..T+ITERS, DONE in T+ITERS+1. `muldiv_stall_req` is high from T through T+ITERS. Total latency is ITERS+2 cycles, of which ITERS+1 are stall cycles.
- Early-out: BUSY in T+1, DONE in T+2.
- Back-to-back M instructions: the next start can be accepted at T+ITERS+2.
- `muldiv_result` is registered and is stable through the DONE cycle.

## Configuration

- `MULDIV_FAST_MUL_EN` defined:
  - Multiply ops compute the full 64-bit signed, unsigned, or mixed product in one combinational step during the single BUSY cycle, with DONE at T+2.
  - Divide is unchanged.
- Undefined: multiply uses the iterative path with ITERS cycles.
- Flush and reset behaviour is identical in both builds.

## Structure

- Shared package `riscv_pkg`:
  - `muldiv_op_e` enum, using the funct3 encoding above.
  - `muldiv_state_e` enum (IDLE, BUSY, DONE).
  - `XLEN` constant.
  - Constants `DIV_BY_ZERO_Q` (0xFFFFFFFF) and `INT_MIN` (0x80000000).
- One sub-module, `muldiv_iter_core`: a single radix-2 step shared by the multiply and divide datapaths, taking the accumulator, operand, and mode and returning the next accumulator.
- The hazard unit ORs `muldiv_stall_req` into its front-end stall and ID/EX hold.

## Test plan

- MUL 7 * -3 → result 0xFFFFFFEB. `muldiv_stall_req` high for 33 cycles; `muldiv_result_valid` pulses once, at T+33.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU 0xFFFFFFFF * 2 → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 % 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14.
- DIV 5 / 0 → 0xFFFFFFFF and REMU 5 % 0 → 5, each in DONE at T+2. DIV 0x80000000 / -1 → 0x80000000, REM → 0.
- Divide started, `hazard_id_ex_clear` at T+10 → stall drops that cycle, IDLE at T+11, no valid pulse. A new MUL at T+11 completes correctly.
- `rst_n` low at T+5 of a divide → all outputs 0 the next cycle. With `MULDIV_FAST_MUL_EN` defined, MUL 3 * 4 → 12 valid at T+2.
